// File: rtl/ysyx_23060096_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response plus the downstream instruction handshake.
// master is the fetch unit side; slave is the memory/decode side.
interface ysyx_23060096_ifu_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, pc,
    input  inst_ready, redirect_valid, redirect_pc, halt,
    output fetch_misalign
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, pc,
    output inst_ready, redirect_valid, redirect_pc, halt,
    input  fetch_misalign
  );
endinterface

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, holds it for decode.
// Latency accept->inst_valid 2 cycles (3-cycle minimum loop); imem wait states and inst_ready stalls add 1:1.
module ysyx_23060096_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                 clk,
  input logic                 rstn,
  ysyx_23060096_ifu_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        misalign_q;
  logic        req_valid_q;
  logic        inst_valid_q;

  // Handshake valid flops track the state so every output is a register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      misalign_q   <= 1'b0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.imem_req_ready) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            inst_q       <= bus.imem_resp_data;
            state        <= S_HOLD;
            inst_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            if (bus.halt) begin
              state <= S_HALTED;
            end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
              misalign_q <= 1'b1;
              state      <= S_HALTED;
            end else if (bus.redirect_valid) begin
              pc_q        <= bus.redirect_pc;
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              pc_q        <= pc_q + 32'd4;
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_HALTED;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.fetch_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Bench for the fetch unit: table of fetch transactions plus hand sequences for halt and reset-in-WAIT.
module tb_ysyx_23060096_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  ysyx_23060096_ifu_if bus ();

  ysyx_23060096_ifu #(.RESET_PC(RST_PC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    int          req_wait;
    int          resp_wait;
    int          hold_wait;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        hlt;
    logic [31:0] exp_next;
    logic        exp_halt;
    logic        exp_mis;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[7];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.halt            = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_inputs();
    sb_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk1("rst_req_valid", bus.imem_req_valid, 1'b1);
    chk ("rst_req_addr",  bus.imem_req_addr,  RST_PC);
    chk1("rst_inst_valid", bus.inst_valid,    1'b0);
    chk ("rst_inst",      bus.inst,           32'h0000_0013);
    chk ("rst_pc",        bus.pc,             RST_PC);
    chk1("rst_misalign",  bus.fetch_misalign, 1'b0);
    exp_pc = RST_PC;
  endtask

  // Entered at a falling edge with the DUT in REQ; leaves at a falling edge after the handshake.
  task automatic fetch(input vec_t v);
    sb_t e;
    chk1("req_valid", bus.imem_req_valid, 1'b1);
    chk ("req_addr",  bus.imem_req_addr,  exp_pc);
    for (int i = 0; i < v.req_wait; i++) begin
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hBAD0_0000 + i;
      @(negedge clk);
      chk1("req_stall_valid", bus.imem_req_valid, 1'b1);
      chk ("req_stall_addr",  bus.imem_req_addr,  exp_pc);
    end
    bus.imem_resp_valid = 1'b0;
    bus.imem_req_ready  = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk1("wait_req_valid", bus.imem_req_valid, 1'b0);
    for (int i = 0; i < v.resp_wait; i++) begin
      @(negedge clk);
      chk1("wait_inst_valid", bus.inst_valid, 1'b0);
    end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = v.data;
    sb_q.push_back('{addr: exp_pc, data: v.data});
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    chk1("hold_inst_valid", bus.inst_valid, 1'b1);
    for (int i = 0; i < v.hold_wait; i++) begin
      // Stray controls and a stray response must not disturb a held instruction.
      bus.inst_ready      = 1'b0;
      bus.halt            = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_pc     = 32'h1234_5677;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hBAD1_0000 + i;
      @(negedge clk);
      chk1("stall_inst_valid", bus.inst_valid,     1'b1);
      chk1("stall_req_valid",  bus.imem_req_valid, 1'b0);
      chk ("stall_inst",       bus.inst,           v.data);
      chk ("stall_pc",         bus.pc,             exp_pc);
    end
    clear_inputs();
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
    bus.halt           = v.hlt;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got handshake, expected no pending entry");
    end else begin
      e = sb_q.pop_front();
      chk("hs_inst", bus.inst, e.data);
      chk("hs_pc",   bus.pc,   e.addr);
    end
    @(negedge clk);
    clear_inputs();
    chk1("post_inst_valid", bus.inst_valid, 1'b0);
    if (v.exp_halt) begin
      chk1("post_req_halted", bus.imem_req_valid, 1'b0);
    end else begin
      chk1("post_req_valid", bus.imem_req_valid, 1'b1);
      chk ("post_req_addr",  bus.imem_req_addr,  v.exp_next);
      exp_pc = v.exp_next;
    end
    chk1("post_misalign", bus.fetch_misalign, v.exp_mis);
  endtask

  task automatic check_halted(input logic exp_mis, input logic [31:0] exp_hpc);
    for (int i = 0; i < 6; i++) begin
      bus.imem_req_ready  = 1'b1;
      bus.inst_ready      = 1'b1;
      bus.imem_resp_valid = i[0];
      bus.imem_resp_data  = 32'hBAD2_0000;
      @(negedge clk);
      chk1("halted_req_valid",  bus.imem_req_valid, 1'b0);
      chk1("halted_inst_valid", bus.inst_valid,     1'b0);
      chk1("halted_misalign",   bus.fetch_misalign, exp_mis);
      chk ("halted_pc",         bus.pc,             exp_hpc);
    end
    clear_inputs();
  endtask

  vec_t hv;

  initial begin
    clear_inputs();
    exp_pc = RST_PC;
    //       rw rsw hw  data           redir rpc            hlt   next           halt  mis
    vecs[0] = '{0, 0, 0, 32'h0010_0093, 1'b0, 32'h0,         1'b0, 32'h8000_0004, 1'b0, 1'b0};
    vecs[1] = '{4, 3, 0, 32'h0020_0113, 1'b0, 32'h0,         1'b0, 32'h8000_0008, 1'b0, 1'b0};
    vecs[2] = '{0, 0, 5, 32'h0030_0193, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0100, 1'b0, 1'b0};
    vecs[3] = '{1, 1, 1, 32'h0040_0213, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[4] = '{0, 0, 0, 32'h0050_0293, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{0, 2, 0, 32'h0060_0313, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
    vecs[6] = '{0, 0, 0, 32'h0070_0393, 1'b1, 32'h8000_0102, 1'b0, 32'h0,         1'b1, 1'b1};

    do_reset();
    for (int k = 0; k < 7; k++) fetch(vecs[k]);
    check_halted(1'b1, 32'h0000_0010);

    // Halt wins over a simultaneous redirect and leaves pc untouched.
    do_reset();
    hv = '{0, 0, 2, 32'h0010_0073, 1'b1, 32'h8000_0200, 1'b1, 32'h0, 1'b1, 1'b0};
    fetch(hv);
    check_halted(1'b0, RST_PC);

    // Reset while waiting for a response; the late response lands in REQ and is dropped.
    do_reset();
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk1("rw_in_wait", bus.imem_req_valid, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk1("rw_async_req_valid", bus.imem_req_valid, 1'b1);
    chk ("rw_async_addr",      bus.imem_req_addr,  RST_PC);
    @(negedge clk);
    rstn = 1'b1;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    chk1("rw_req_valid",  bus.imem_req_valid, 1'b1);
    chk ("rw_req_addr",   bus.imem_req_addr,  RST_PC);
    chk ("rw_inst",       bus.inst,           32'h0000_0013);
    chk1("rw_inst_valid", bus.inst_valid,     1'b0);
    exp_pc = RST_PC;
    sb_q.delete();
    hv = '{0, 0, 0, 32'h00A0_0513, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 1'b0, 1'b0};
    fetch(hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
